// File: rtl/hvac_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hvac_ramp_ctrl
//  Description : Heater/cooler actuator sequencer. Accepts a target
//                (power level, heat/cool mode) over a valid/ready handshake
//                and walks the actuator toward it one power step at a time.
//                A mode reversal always ramps power to zero and holds a
//                dead time at zero before the new mode is applied.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STEP_CYCLES  clock cycles per single power step (>=1)
//    DEAD_CYCLES  clock cycles held at zero power before a reversal (>=1)
//    MAX_POWER    highest allowed power level (<=15)
//
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-high reset
//    abort      in   cancel the running target (HVAC_ABORT_EN builds only)
//    req_valid  in   new target present
//    req_ready  out  block can accept a target (IDLE and not in reset)
//    req_power  in   target power level (clamped to MAX_POWER)
//    req_mode   in   target mode, heat=1 / cool=0
//    act_power  out  power currently applied to the actuator
//    act_mode   out  mode currently applied, heat=1 / cool=0
//    act_en     out  actuator enabled (act_power != 0)
//    busy       out  high in any state other than IDLE
//    done       out  one-cycle pulse when the target is reached
//    clip       out  one-cycle pulse when the accepted req_power was clamped
//
//  Build option
//    HVAC_ABORT_EN  when defined, adds the abort input. abort in a ramp
//                   retargets to zero power (keeping the present mode);
//                   abort in the dead time returns to IDLE at the next edge.
// ============================================================================
module hvac_ramp_ctrl #(
    parameter int STEP_CYCLES = 16,
    parameter int DEAD_CYCLES = 32,
    parameter int MAX_POWER   = 8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef HVAC_ABORT_EN
    input  logic       abort,
`endif
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_power,
    input  logic       req_mode,
    output logic [3:0] act_power,
    output logic       act_mode,
    output logic       act_en,
    output logic       busy,
    output logic       done,
    output logic       clip
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // One shared timer serves both the step interval and the dead time,
    // so it is sized for the longer of the two.
    localparam int c_TMR_MAX = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES
                                                            : DEAD_CYCLES;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_STEP_LAST = c_TMR_W'(STEP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DEAD_LAST = c_TMR_W'(DEAD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ZERO  = '0;
    localparam logic [3:0]         c_MAX_PWR   = 4'(MAX_POWER);
    localparam logic [3:0]         c_PWR_ZERO  = 4'd0;
    localparam logic [3:0]         c_PWR_ONE   = 4'd1;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] c_ST_RAMP_DOWN = 2'd2;
    localparam logic [1:0] c_ST_DEAD      = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [3:0]         r_act_power;
    logic               r_act_mode;
    logic [3:0]         r_tgt_power;
    logic               r_tgt_mode;
    logic               r_mode_pend;   // reversal in progress: ramp to 0, then DEAD
    logic               r_done;
    logic               r_clip;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_req_clip;
    logic [3:0] w_req_pwr_sat;
    logic [3:0] w_pwr_inc;
    logic [3:0] w_pwr_dec;
    logic       w_step_tc;
    logic       w_dead_tc;
    logic       w_abort;

    assign w_req_clip    = (req_power > c_MAX_PWR);
    assign w_req_pwr_sat = w_req_clip ? c_MAX_PWR : req_power;
    assign w_pwr_inc     = r_act_power + c_PWR_ONE;
    assign w_pwr_dec     = r_act_power - c_PWR_ONE;
    assign w_step_tc     = (r_tmr == c_STEP_LAST);
    assign w_dead_tc     = (r_tmr == c_DEAD_LAST);

`ifdef HVAC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_tmr       <= c_TMR_ZERO;
            r_act_power <= c_PWR_ZERO;
            r_act_mode  <= 1'b0;
            r_tgt_power <= c_PWR_ZERO;
            r_tgt_mode  <= 1'b0;
            r_mode_pend <= 1'b0;
            r_done      <= 1'b0;
            r_clip      <= 1'b0;
        end else begin
            // Status pulses are one cycle wide unless re-asserted below.
            r_done <= 1'b0;
            r_clip <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    // req_ready is simply "IDLE and out of reset", and reset
                    // is already known low here, so req_valid alone accepts.
                    if (req_valid) begin
                        r_tgt_power <= w_req_pwr_sat;
                        r_tgt_mode  <= req_mode;
                        r_clip      <= w_req_clip;
                        r_tmr       <= c_TMR_ZERO;
                        if (req_mode == r_act_mode) begin
                            r_mode_pend <= 1'b0;
                            if (w_req_pwr_sat == r_act_power) begin
                                // Already there: acknowledge without moving.
                                r_done <= 1'b1;
                            end else if (w_req_pwr_sat > r_act_power) begin
                                r_state <= c_ST_RAMP_UP;
                            end else begin
                                r_state <= c_ST_RAMP_DOWN;
                            end
                        end else begin
                            // Reversal: never switch mode while powered.
                            r_mode_pend <= 1'b1;
                            if (r_act_power != c_PWR_ZERO) begin
                                r_state <= c_ST_RAMP_DOWN;
                            end else begin
                                r_state <= c_ST_DEAD;
                            end
                        end
                    end
                end

                c_ST_RAMP_UP: begin
                    if (w_abort) begin
                        // Retarget to zero in the present mode; the step
                        // interval restarts from the abort edge.
                        r_tgt_power <= c_PWR_ZERO;
                        r_mode_pend <= 1'b0;
                        r_tmr       <= c_TMR_ZERO;
                        if (r_act_power == c_PWR_ZERO) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_RAMP_DOWN;
                        end
                    end else if (w_step_tc) begin
                        r_tmr       <= c_TMR_ZERO;
                        r_act_power <= w_pwr_inc;
                        if (w_pwr_inc == r_tgt_power) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                c_ST_RAMP_DOWN: begin
                    if (w_abort) begin
                        r_tgt_power <= c_PWR_ZERO;
                        r_mode_pend <= 1'b0;
                        r_tmr       <= c_TMR_ZERO;
                        if (r_act_power == c_PWR_ZERO) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_step_tc) begin
                        r_tmr       <= c_TMR_ZERO;
                        r_act_power <= w_pwr_dec;
                        if (r_mode_pend) begin
                            // During a reversal the final target is applied
                            // only after the dead time, so ramp all the way
                            // to zero regardless of r_tgt_power.
                            if (w_pwr_dec == c_PWR_ZERO) begin
                                r_state <= c_ST_DEAD;
                            end
                        end else if (w_pwr_dec == r_tgt_power) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                c_ST_DEAD: begin
                    if (w_abort) begin
                        // Abandon the reversal; the old mode stays applied.
                        r_tgt_power <= c_PWR_ZERO;
                        r_mode_pend <= 1'b0;
                        r_tmr       <= c_TMR_ZERO;
                        r_state     <= c_ST_IDLE;
                        r_done      <= 1'b1;
                    end else if (w_dead_tc) begin
                        // The only place act_mode is ever changed.
                        r_act_mode  <= r_tgt_mode;
                        r_mode_pend <= 1'b0;
                        r_tmr       <= c_TMR_ZERO;
                        if (r_tgt_power == c_PWR_ZERO) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_RAMP_UP;
                        end
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_tmr       <= c_TMR_ZERO;
                    r_mode_pend <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // req_ready is qualified by rst combinationally so that it drops the
    // instant reset is asserted, not just at the next clock.
    assign req_ready = (r_state == c_ST_IDLE) && !rst;
    assign act_power = r_act_power;
    assign act_mode  = r_act_mode;
    assign act_en    = (r_act_power != c_PWR_ZERO);
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign clip      = r_clip;

endmodule

`default_nettype wire
